result_uart_tx: RTL and testbench
=================================

Name: result_uart_tx

Overview:
- Serial transmitter for the SAD match result: returns the best-match coordinates (x 10-bit, y 9-bit) to the host over the same UART link the image data arrives on.
- Latches one coordinate pair on a valid/ready handshake and frames it as a fixed 5-byte packet.
- Serializes the packet as 8N1, LSB first, at a parameterized baud rate.
- Sits beside the UART receiver at the board top level and is driven by the processor's valid_out, x_out and y_out.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥2.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clock  input  1  system clock; all logic on rising edge
- notReset  input  1  synchronous, active-low reset
- result_valid  input  1  coordinate pair present; accepted only when result_ready=1
- x_in  input  10  x coordinate
- y_in  input  9  y coordinate
- result_ready  output  1  high when idle and able to accept a pair
- busy  output  1  high from accept until packet done
- done  output  1  one-cycle pulse after the last stop bit of the packet
- TxD  output  1  serial line; idle high

Behaviour:
- Reset (notReset=0 at a clock edge): state=IDLE, TxD=1, busy=0, done=0, result_ready=1, all counters 0.
- Reset mid-packet: transmission abandoned; TxD=1 from the next edge; no done pulse.
- Accept: result_valid=1 and result_ready=1 at an edge. x_in and y_in are latched and the FSM enters START. busy=1 and result_ready=0 from that edge.
- result_valid while busy: ignored; no queuing. The latched values are unaffected by input changes after accept.
- Packet byte order:
  - B0 = HEADER
  - B1 = {6'b0, x[9:8]}
  - B2 = x[7:0]
  - B3 = {7'b0, y[8]}
  - B4 = y[7:0]
- Byte frame:
  - start bit 0, then data bits d0..d7 (LSB first), then stop bit 1.
  - Every bit is held for exactly CLKS_PER_BIT cycles; frame length = 10*CLKS_PER_BIT cycles.
- No inter-byte gap: the start bit of byte n+1 follows the stop bit of byte n directly.
- Packet length = 50*CLKS_PER_BIT cycles from accept to return to IDLE.
- Latency: TxD falls on the same edge that accepts the pair, i.e. it is registered out of the START state.
- FSM (baud counter counts 0..CLKS_PER_BIT-1; each bit ends at terminal count):
  - IDLE: TxD=1. On accept → START, byte index=0.
  - START: TxD=0. At terminal count → DATA, bit index=0.
  - DATA: TxD = current byte[bit index]. At terminal count: bit index=7 → STOP, otherwise bit index+1.
  - STOP: TxD=1. At terminal count: byte index=4 → IDLE, otherwise byte index+1 and → START.
- Completion: on the STOP→IDLE edge, done=1 for exactly one cycle, busy=0 and result_ready=1.
- Back-to-back: result_valid=1 in the cycle done=1 is accepted, since ready is already high. The next packet's start bit begins on that edge.
- All outputs are registered; TxD carries no combinational path from any input.
- Counter widths: baud counter width = clog2(CLKS_PER_BIT); 3-bit bit index; 3-bit byte index. Wrap-around occurs only via the explicit transitions above.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset: hold notReset=0 for 3 cycles while result_valid=1 → TxD=1, busy=0, result_ready=1, done=0 throughout; no accept.
- Single packet: x=10'd637 (0x27D), y=9'd300 (0x12C), valid for 1 cycle.
  - Expected bytes A5, 02, 7D, 01, 2C, each sampled mid-bit as 0, LSB-first data, then 1.
  - Packet spans exactly 200 cycles; done pulses once, 200 cycles after accept.
- Valid while busy: a second pulse at cycle 50 with x=5, y=5 → ignored; the bitstream still carries 637/300.
- Back-to-back: valid held high with x=0, y=511.
  - Second packet is accepted in the done cycle with no idle bit between packets.
  - Second packet bytes are A5, 00, 00, 01, FF.
- Reset mid-packet: assert notReset=0 at cycle 90 → TxD=1 next edge, no done pulse. A new pair accepted after release transmits correctly from its header.
- Timing at default CLKS_PER_BIT=434: x=1023, y=0 → each bit is exactly 434 cycles, the packet is 21700 cycles, and the bytes are A5, 03, FF, 00, 00.

Source files
------------

// File: rtl/result_uart_tx.sv
// 8N1 serial transmitter for the SAD best-match result: frames {x, y} as a
// 5-byte packet (header, x hi, x lo, y hi, y lo) and shifts it out LSB first.
module result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic       clock,
   input  logic       notReset,
   input  logic       result_valid,
   input  logic [9:0] x_in,
   input  logic [8:0] y_in,
   output logic       result_ready,
   output logic       busy,
   output logic       done,
   output logic       TxD
);

   localparam int unsigned    CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [2:0]      byte_idx_q, byte_idx_d;
   logic [9:0]      x_q, x_d;
   logic [8:0]      y_q, y_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;

   logic [7:0]      cur_byte;
   logic [2:0]      bit_nxt;
   logic            baud_end;

   always_comb begin
      case (byte_idx_q)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = {6'b0, x_q[9:8]};
         3'd2:    cur_byte = x_q[7:0];
         3'd3:    cur_byte = {7'b0, y_q[8]};
         default: cur_byte = y_q[7:0];
      endcase
   end

   assign baud_end = (baud_q == CntMax);
   assign bit_nxt  = bit_idx_q + 3'd1;

   // TxD is computed for the state being entered, so the line changes on the
   // same edge as the state and stays a plain register output.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      x_d        = x_q;
      y_d        = y_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ready_d    = ready_q;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (result_valid && ready_q) begin
               x_d        = x_in;
               y_d        = y_in;
               state_d    = StStart;
               baud_d     = '0;
               byte_idx_d = 3'd0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d    = '0;
               state_d   = StData;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_nxt;
                  tx_d      = cur_byte[bit_nxt];
               end
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               if (byte_idx_q == 3'd4) begin
                  state_d    = StIdle;
                  byte_idx_d = 3'd0;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  ready_d    = 1'b1;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = StStart;
                  tx_d       = 1'b0;
               end
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!notReset) begin
         state_q    <= StIdle;
         baud_q     <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 3'd0;
         x_q        <= 10'd0;
         y_q        <= 9'd0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         x_q        <= x_d;
         y_q        <= y_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign TxD          = tx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_ready = ready_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: a fast instance (4 clocks/bit) for the
// protocol cases and a default-rate instance for bit and packet timing.
module tb_result_uart_tx;

   logic       clock = 1'b0;
   logic       notReset;
   logic       valid;
   logic [9:0] x_r;
   logic [8:0] y_r;
   logic       use_slow;

   logic ready_f, busy_f, done_f, tx_f;
   logic ready_s, busy_s, done_s, tx_s;
   logic ready_m, busy_m, done_m, tx_m;

   always #5 clock = ~clock;

   result_uart_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) u_fast (
      .clock        (clock),
      .notReset     (notReset),
      .result_valid (valid & ~use_slow),
      .x_in         (x_r),
      .y_in         (y_r),
      .result_ready (ready_f),
      .busy         (busy_f),
      .done         (done_f),
      .TxD          (tx_f)
   );

   result_uart_tx u_slow (
      .clock        (clock),
      .notReset     (notReset),
      .result_valid (valid & use_slow),
      .x_in         (x_r),
      .y_in         (y_r),
      .result_ready (ready_s),
      .busy         (busy_s),
      .done         (done_s),
      .TxD          (tx_s)
   );

   assign ready_m = use_slow ? ready_s : ready_f;
   assign busy_m  = use_slow ? busy_s  : busy_f;
   assign done_m  = use_slow ? done_s  : done_f;
   assign tx_m    = use_slow ? tx_s    : tx_f;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int pkt_end_cyc = -10;

   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge done_f or posedge done_s) done_cnt = done_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      bit          hold;   // keep valid high through the done cycle
      bit          poke;   // extra valid pulse (x=5,y=5) 50 cycles in
      bit          b2b;    // must be accepted right in the previous done cycle
      logic [39:0] bytes;  // B0..B4, B0 in the top byte
   } vec_t;

   task automatic run_packet(input int clks, input vec_t v);
      int          waited;
      int          acc_cyc;
      int          d0;
      bit          early_done;
      logic [49:0] bits;
      logic [9:0]  frame;
      logic [7:0]  exp_b;
      waited     = 0;
      early_done = 0;
      bits       = '0;
      x_r        = v.x;
      y_r        = v.y;
      valid      = 1'b1;
      while (!ready_m && waited < 1000) begin
         @(posedge clock);
         #1;
         waited++;
      end
      if (waited >= 1000) check("ready_timeout", 0, 1);
      d0 = done_cnt;
      @(posedge clock);
      #1;
      acc_cyc = cyc;
      if (!v.hold) valid = 1'b0;
      if (v.b2b) check("b2b_gap_cycles", acc_cyc - pkt_end_cyc, 1);
      check("accept_txd", int'(tx_m), 0);
      check("accept_busy", int'(busy_m), 1);
      check("accept_ready", int'(ready_m), 0);
      for (int rel = 1; rel <= 50 * clks; rel++) begin
         @(posedge clock);
         #1;
         if (v.poke && rel == 50) begin
            valid = 1'b1;
            x_r   = 10'd5;
            y_r   = 9'd5;
         end
         if (v.poke && rel == 51) valid = 1'b0;
         if (rel < 50 * clks && done_m) early_done = 1;
         if (rel % clks == clks / 2 && rel < 50 * clks) bits[rel / clks] = tx_m;
         if (rel == clks - 1) check("start_bit_tail", int'(tx_m), 0);
         if (rel == clks) check("hdr_d0_edge", int'(tx_m), 1);
      end
      pkt_end_cyc = cyc;
      check("end_done", int'(done_m), 1);
      check("end_busy", int'(busy_m), 0);
      check("end_ready", int'(ready_m), 1);
      check("end_txd", int'(tx_m), 1);
      check("early_done", int'(early_done), 0);
      check("done_count", done_cnt - d0, 1);
      for (int b = 0; b < 5; b++) begin
         frame = bits[b*10 +: 10];
         exp_b = v.bytes[39 - 8*b -: 8];
         check($sformatf("frame_b%0d", b), int'(frame), int'({1'b1, exp_b, 1'b0}));
      end
      if (!v.hold) begin
         @(posedge clock);
         #1;
         check("done_one_cycle", int'(done_m), 0);
      end
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{x: 10'd637,  y: 9'd300, hold: 0, poke: 1, b2b: 0, bytes: 40'hA5_02_7D_01_2C};
      vecs[1] = '{x: 10'd0,    y: 9'd511, hold: 1, poke: 0, b2b: 0, bytes: 40'hA5_00_00_01_FF};
      vecs[2] = '{x: 10'd0,    y: 9'd511, hold: 0, poke: 0, b2b: 1, bytes: 40'hA5_00_00_01_FF};
      vecs[3] = '{x: 10'd1023, y: 9'd0,   hold: 0, poke: 0, b2b: 0, bytes: 40'hA5_03_FF_00_00};
      vecs[4] = '{x: 10'h2AA,  y: 9'h155, hold: 0, poke: 0, b2b: 0, bytes: 40'hA5_02_AA_01_55};

      use_slow = 1'b0;
      notReset = 1'b0;
      valid    = 1'b1;
      x_r      = 10'd1;
      y_r      = 9'd1;

      // Reset held with valid asserted: nothing may be accepted.
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("rst_txd", int'(tx_m), 1);
         check("rst_busy", int'(busy_m), 0);
         check("rst_ready", int'(ready_m), 1);
         check("rst_done", int'(done_m), 0);
      end
      valid    = 1'b0;
      notReset = 1'b1;
      @(posedge clock);
      #1;
      check("post_rst_idle_busy", int'(busy_m), 0);

      for (int i = 0; i < 5; i++) run_packet(4, vecs[i]);

      // Reset mid-packet, 90 cycles after accept (inside a 0 data bit of B2).
      begin
         int d0;
         x_r   = 10'd637;
         y_r   = 9'd300;
         valid = 1'b1;
         @(posedge clock);
         #1;
         valid = 1'b0;
         repeat (89) @(posedge clock);
         #1;
         check("pre_rst_txd", int'(tx_m), 0);
         d0       = done_cnt;
         notReset = 1'b0;
         @(posedge clock);
         #1;
         check("midrst_txd", int'(tx_m), 1);
         check("midrst_busy", int'(busy_m), 0);
         check("midrst_ready", int'(ready_m), 1);
         repeat (2) @(posedge clock);
         #1;
         notReset = 1'b1;
         repeat (250) @(posedge clock);
         #1;
         check("midrst_no_done", done_cnt - d0, 0);
         check("midrst_idle_txd", int'(tx_m), 1);
      end
      run_packet(4, vecs[3]);

      // Default rate: 434 clocks per bit, 21700 per packet.
      use_slow = 1'b1;
      run_packet(434, vecs[3]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
